// File: rtl/kernel_bc_w64_unpack32.sv
// Splits 64-bit vertex-pair words into a 32-bit stream (low half first),
// optionally dropping padding halves, under ap_start/ap_done control.
module kernel_bc_w64_unpack32 #(
    parameter bit          DROP_PAD  = 1'b1,
    parameter logic [31:0] PAD_VALUE = 32'hFFFF_FFFF,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ap_start,
    output logic                 ap_done,
    output logic                 ap_idle,
    input  logic [CNT_WIDTH-1:0] num_words,
    input  logic                 in_empty_n,
    output logic                 in_read,
    input  logic [63:0]          in_dout,
    input  logic                 out_full_n,
    output logic                 out_write,
    output logic [31:0]          out_din,
    output logic [CNT_WIDTH-1:0] out_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] remaining;
    logic [63:0]          word_q;
    logic                 lo_v;
    logic                 hi_v;

    logic running;
    logic emit;
    logic can_load;
    logic lo_keep;
    logic hi_keep;

    // Handshakes are gated by reset so an in-flight run cannot pop or push
    // during the reset cycle itself.
    assign running   = (state == RUN) && !reset;
    assign emit      = running && out_full_n && (lo_v || hi_v);
    assign can_load  = !(lo_v || hi_v) || (!lo_v && hi_v && emit);
    assign in_read   = running && in_empty_n && (remaining != '0) && can_load;
    assign out_write = emit;
    assign out_din   = lo_v ? word_q[31:0] : word_q[63:32];

    assign lo_keep = !(DROP_PAD && (in_dout[31:0] == PAD_VALUE));
    assign hi_keep = !(DROP_PAD && (in_dout[63:32] == PAD_VALUE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ap_idle   <= 1'b1;
            ap_done   <= 1'b0;
            remaining <= '0;
            out_count <= '0;
            word_q    <= '0;
            lo_v      <= 1'b0;
            hi_v      <= 1'b0;
        end else begin
            ap_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        remaining <= num_words;
                        out_count <= '0;
                        ap_idle   <= 1'b0;
                        if (num_words == '0) begin
                            state   <= DONE;
                            ap_done <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // A load may overwrite a high half that leaves this same cycle.
                    if (in_read) begin
                        word_q    <= in_dout;
                        lo_v      <= lo_keep;
                        hi_v      <= hi_keep;
                        remaining <= remaining - CNT_ONE;
                    end else if (emit) begin
                        if (lo_v) lo_v <= 1'b0;
                        else      hi_v <= 1'b0;
                    end
                    if (emit) out_count <= out_count + CNT_ONE;
                    if ((remaining == '0) && !lo_v && !hi_v) begin
                        state   <= DONE;
                        ap_done <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ap_idle <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ap_idle <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_bc_w64_unpack32.sv
// Scoreboard bench: a FIFO model feeds the DUT, a reference model derives the
// expected 32-bit stream from each job's words, and a monitor checks outputs.
module tb_kernel_bc_w64_unpack32;

    localparam logic [31:0] PAD = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic [31:0] num_words;
    logic        in_empty_n;
    logic        in_read;
    logic [63:0] in_dout;
    logic        out_full_n;
    logic        out_write;
    logic [31:0] out_din;
    logic [31:0] out_count;

    kernel_bc_w64_unpack32 dut (
        .clk        (clk),
        .reset      (reset),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .num_words  (num_words),
        .in_empty_n (in_empty_n),
        .in_read    (in_read),
        .in_dout    (in_dout),
        .out_full_n (out_full_n),
        .out_write  (out_write),
        .out_din    (out_din),
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    logic [63:0] fifo_q[$];
    logic [63:0] job_words[$];
    logic [31:0] exp_q[$];

    int compared = 0;
    int mismatched = 0;
    int cycle = 0;
    int bp_mode = 0;     // 0: always ready, 1: alternate, 2: random
    int in_mode = 0;     // 0: data always offered, 1: random gaps
    int reads = 0;
    int writes = 0;
    int done_pulses = 0;
    int first_wr = 0;
    int last_wr = 0;
    int base_done = 0;
    int exp_reads = 0;
    int exp_cnt = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Input FIFO and output-side backpressure model
    initial begin
        bit          alt;
        logic        rd;
        logic [63:0] dropped;
        alt = 1'b0;
        out_full_n = 1'b1;
        in_empty_n = 1'b0;
        in_dout = '0;
        forever begin
            @(negedge clk);
            alt = ~alt;
            case (bp_mode)
                0:       out_full_n = 1'b1;
                1:       out_full_n = alt;
                default: out_full_n = ($urandom_range(0, 3) != 0);
            endcase
            in_empty_n = (fifo_q.size() > 0) &&
                         ((in_mode == 0) || ($urandom_range(0, 2) != 0));
            in_dout = (fifo_q.size() > 0) ? fifo_q[0] : 64'h0;
            #2;
            rd = in_read;
            @(posedge clk);
            if (rd && fifo_q.size() > 0) begin
                dropped = fifo_q.pop_front();
                reads++;
            end
        end
    end

    // Monitor
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (ap_done) done_pulses++;
            if (in_read) check("read_needs_data", in_empty_n, 1);
            if (out_write) begin
                check("write_needs_space", out_full_n, 1);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_write: got %0h, expected no write", out_din);
                end else begin
                    e = exp_q.pop_front();
                    check("out_din", out_din, e);
                end
                writes++;
                if (writes == 1) first_wr = cycle;
                last_wr = cycle;
            end
        end
    end

    // Reference: every half of the first nw words, low first, minus padding
    task automatic start_job(input int nw, input int preload);
        logic [31:0] half;
        exp_q.delete();
        fifo_q.delete();
        exp_cnt = 0;
        exp_reads = (nw < job_words.size()) ? nw : job_words.size();
        for (int i = 0; i < exp_reads; i++) begin
            for (int h = 0; h < 2; h++) begin
                half = (h == 0) ? job_words[i][31:0] : job_words[i][63:32];
                if (half != PAD) begin
                    exp_q.push_back(half);
                    exp_cnt++;
                end
            end
        end
        for (int i = 0; i < preload; i++) fifo_q.push_back(job_words[i]);
        base_done = done_pulses;
        reads = 0;
        writes = 0;
        @(negedge clk);
        ap_start = 1'b1;
        num_words = nw;
        @(negedge clk);
        ap_start = 1'b0;
        #2;
        check("idle_drops", ap_idle, 0);
        if (nw == 0) check("zero_done_next_cycle", ap_done, 1);
    endtask

    task automatic finish_job(input int span);
        int k;
        k = 0;
        while (done_pulses == base_done && k < 3000) begin
            @(negedge clk);
            #3;
            k++;
        end
        repeat (3) @(negedge clk);
        #3;
        check("done_pulses", done_pulses - base_done, 1);
        check("exp_drained", exp_q.size(), 0);
        check("writes", writes, exp_cnt);
        check("reads", reads, exp_reads);
        check("out_count", out_count, exp_cnt);
        check("fifo_left", fifo_q.size(), job_words.size() - exp_reads);
        check("idle_after", ap_idle, 1);
        if (span >= 0) check("write_span", last_wr - first_wr, span);
    endtask

    initial begin
        int k;
        int nw;
        int extra;
        logic [31:0] lo;
        logic [31:0] hi;

        reset = 1'b1;
        ap_start = 1'b0;
        num_words = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #2;
        check("rst_in_read", in_read, 0);
        check("rst_out_write", out_write, 0);
        check("rst_ap_idle", ap_idle, 1);
        check("rst_ap_done", ap_done, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_din", out_din, 0);

        // basic split, back-to-back
        job_words = '{64'h00000002_00000001, 64'h00000004_00000003};
        start_job(2, 2);
        finish_job(3);

        // alternating backpressure
        bp_mode = 1;
        start_job(2, 2);
        finish_job(-1);
        bp_mode = 0;

        // padding
        job_words = '{64'hFFFFFFFF_00000007, 64'hFFFFFFFF_FFFFFFFF, 64'h00000009_FFFFFFFF};
        start_job(3, 3);
        finish_job(-1);
        check("pad_count", out_count, 2);

        // zero words
        job_words = '{64'h00000011_00000010};
        start_job(0, 1);
        finish_job(-1);

        // limit: one word requested, three queued
        job_words = '{64'h00000021_00000020, 64'h00000023_00000022, 64'h00000025_00000024};
        start_job(1, 3);
        finish_job(-1);
        check("limit_left", fifo_q.size(), 2);

        // starvation between words
        job_words = '{64'h00000031_00000030, 64'h00000033_00000032};
        start_job(2, 1);
        k = 0;
        while ((writes < 2 || fifo_q.size() != 0) && k < 200) begin
            @(negedge clk);
            #3;
            k++;
        end
        repeat (5) @(negedge clk);
        #3;
        check("starve_no_writes", writes, 2);
        @(posedge clk);
        #1;
        fifo_q.push_back(job_words[1]);
        @(negedge clk);
        #3;
        check("starve_resume_read", in_read, 1);
        finish_job(-1);

        // reset after the first low-half emit
        job_words = '{64'h00000042_00000041, 64'h00000044_00000043};
        start_job(2, 2);
        k = 0;
        while (writes < 1 && k < 100) begin
            @(negedge clk);
            #3;
            k++;
        end
        check("pre_reset_writes", writes, 1);
        @(negedge clk);
        reset = 1'b1;
        #2;
        check("rstcyc_in_read", in_read, 0);
        check("rstcyc_out_write", out_write, 0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("postrst_in_read", in_read, 0);
        check("postrst_out_write", out_write, 0);
        check("postrst_ap_idle", ap_idle, 1);
        check("postrst_ap_done", ap_done, 0);
        check("postrst_out_count", out_count, 0);
        check("postrst_out_din", out_din, 0);
        exp_q.delete();
        fifo_q.delete();
        job_words = '{64'h00000066_00000055};
        start_job(1, 1);
        finish_job(-1);

        // randomized jobs with backpressure, gaps and padding
        bp_mode = 2;
        in_mode = 1;
        for (int j = 0; j < 8; j++) begin
            nw = $urandom_range(1, 8);
            extra = $urandom_range(0, 2);
            job_words.delete();
            for (int i = 0; i < nw + extra; i++) begin
                lo = ($urandom_range(0, 3) == 0) ? PAD : $urandom();
                hi = ($urandom_range(0, 3) == 0) ? PAD : $urandom();
                job_words.push_back({hi, lo});
            end
            start_job(nw, nw + extra);
            finish_job(-1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
